div_ctrl: RTL
=============

# div_ctrl

Iterative multi-cycle divider sequencer for the EX stage of the MIPS pipeline; executes DIV/DIVU as a 32-step restoring division. While it runs it holds a stall request to pipeline control, which freezes PC/IF/ID/EX and bubbles EX/MEM. On completion it hands EX a 64-bit {remainder, quotient} for the HI/LO write.

## Interface
- DATA_WIDTH, default 32 (`REG_DATA_WIDTH`): operand width; quotient and remainder widths.
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  level request from EX; held high until ready is seen.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opdata1  input  DATA_WIDTH  dividend; sampled with start.
- opdata2  input  DATA_WIDTH  divisor; sampled with start.
- annul  input  1  flush from pipeline control; aborts any operation.
- result  output  2*DATA_WIDTH  {remainder[63:32], quotient[31:0]}.
- ready  output  1  result valid.
- busy  output  1  state != IDLE.
- stall_req  output  1  start & ~ready & ~annul (combinational) to pipeline control.

## Operation
- FSM states: IDLE, ZERO, RUN, DONE. Reset: state IDLE, result 0, ready 0, busy 0, counter 0.
- IDLE: start & ~annul → capture operands. If opdata2 == 0 and `DIV_ZERO_FAST_EN` is defined → ZERO; otherwise → RUN with counter = 0.
- Signed capture: magnitudes |opdata1|, |opdata2| (as unsigned; 0x80000000 stays 0x80000000); record sign_q = sign1 ^ sign2 and sign_r = sign1.
- RUN: per cycle, partial = {rem[30:0], dividend MSB}; if partial >= divisor, rem = partial - divisor and shift in quotient bit 1, else rem = partial and bit 0. Counter increments; after step 32 → DONE with result registered.
- Sign fix at RUN→DONE (signed only, divisor != 0): quotient negated if sign_q; remainder negated if sign_r. Divisor 0 in RUN: no fix; result = {opdata1 raw, 0xFFFFFFFF}.
- ZERO: one cycle; result = {opdata1 raw, 0xFFFFFFFF}; → DONE.
- DONE: ready = 1, result held; stays until start = 0, then → IDLE with ready = 0.
- Overflow 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0, no exception.
- annul: from any state → IDLE next edge, ready 0, result unchanged; annul has priority over start.
- start dropping during RUN/ZERO without annul: operation completes; DONE exits immediately the next edge.

## Timing
- start sampled high at end of cycle 0 → RUN cycles 1..32 → ready high in cycle 33.
- stall_req high cycles 0..32 (33 cycles); low in cycle 33 so EX/MEM latches the result.
- ZERO path: ready in cycle 2; stall_req high cycles 0..1.
- EX deasserts start in the ready cycle; FSM is IDLE in cycle 34. A new start is accepted in cycle 34 at the earliest.
- Reset mid-operation returns to IDLE on the same edge regardless of other inputs.

## Configuration
- `DIV_ZERO_FAST_EN` defined: a zero divisor takes the ZERO path, giving a 2-cycle latency.
- Undefined: a zero divisor runs the full 32-step RUN, with identical result value and 33-cycle latency. The ZERO state is not generated.

## Structure
- Shared defines package: `REG_DATA_WIDTH`, `DOUBLE_DATA_WIDTH`, and state encodings `DIV_IDLE`, `DIV_ZERO`, `DIV_RUN`, `DIV_DONE` (2-bit).
- Sub-module div_step: combinational single restoring iteration (rem_in, dividend bit, divisor → rem_out, q_bit); instantiated once.
- The counter (6-bit), remainder/dividend shift registers and sign flags are local to div_ctrl.

## Test plan
- DIVU 100 / 7 → result {0x00000002, 0x0000000E}; ready first in cycle 33; stall_req high exactly 33 cycles.
- DIV -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}; DIVU same operands → {0x80000000, 0x00000000}.
- DIVU 0x12345678 / 0 → {0x12345678, 0xFFFFFFFF}: with `DIV_ZERO_FAST_EN`, ready in cycle 2; without it, ready in cycle 33.
- annul asserted in cycle 10 of RUN → IDLE in cycle 11, ready never asserted. A new DIVU 9 / 3 started in cycle 11 → {0, 3} in cycle 44.
- rst_n low in cycle 15 of RUN → all outputs 0, state IDLE next cycle. start held high after DONE keeps ready and result stable until start drops.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared widths and divider FSM state encodings for the EX-stage
//               DIV/DIVU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

  // Architectural register width and the HI/LO pair width
  localparam int REG_DATA_WIDTH    = 32;
  localparam int DOUBLE_DATA_WIDTH = 2 * REG_DATA_WIDTH;

  // Divider sequencer states (2-bit encoding)
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_ZERO = 2'd1;
  localparam logic [1:0] DIV_RUN  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration. Shifts the next
//               dividend bit into the partial remainder and subtracts the
//               divisor when it fits.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic                  q_bit
);

  // Partial remainder keeps the bit shifted out of rem_in so that divisors
  // above the half-range still compare correctly in unsigned mode.
  logic [DATA_WIDTH:0] w_partial;

  // Trial subtraction: quotient bit is 1 when the divisor fits
  always_comb begin
    w_partial = {rem_in, dividend_bit};
    q_bit     = (w_partial >= {1'b0, divisor});
    rem_out   = q_bit ? (w_partial[DATA_WIDTH-1:0] - divisor)
                      : w_partial[DATA_WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Iterative 32-step restoring divider sequencer for DIV/DIVU in
//               the EX stage. Raises stall_req while working and returns
//               {remainder, quotient} for the HI/LO write.
//               Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses the
//               iteration through a single ZERO cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    signed_div,
  input  logic [DATA_WIDTH-1:0]   opdata1,
  input  logic [DATA_WIDTH-1:0]   opdata2,
  input  logic                    annul,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    ready,
  output logic                    busy,
  output logic                    stall_req
);

  localparam logic [DATA_WIDTH-1:0] c_all_ones = '1;
  localparam logic [DATA_WIDTH-1:0] c_zero     = '0;
  localparam logic [5:0]            c_last_cnt = 6'(DATA_WIDTH - 1);

  logic [1:0]              r_state;
  logic [5:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   r_rem;
  logic [DATA_WIDTH-1:0]   r_dq;        // dividend shifts out MSB, quotient fills LSB
  logic [DATA_WIDTH-1:0]   r_divisor;
  logic [DATA_WIDTH-1:0]   r_op1_raw;   // original dividend, returned on divide by zero
  logic                    r_signed;
  logic                    r_sign_q;
  logic                    r_sign_r;
  logic [2*DATA_WIDTH-1:0] r_result;
  logic                    r_ready;

  logic [DATA_WIDTH-1:0]   w_abs1;
  logic [DATA_WIDTH-1:0]   w_abs2;
  logic [DATA_WIDTH-1:0]   w_rem_next;
  logic                    w_q_bit;
  logic [DATA_WIDTH-1:0]   w_quot_raw;
  logic [2*DATA_WIDTH-1:0] w_final;

  div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem_in       (r_rem),
    .dividend_bit (r_dq[DATA_WIDTH-1]),
    .divisor      (r_divisor),
    .rem_out      (w_rem_next),
    .q_bit        (w_q_bit)
  );

  // Operand magnitudes for capture; the most negative value maps to itself
  always_comb begin
    w_abs1 = (signed_div && opdata1[DATA_WIDTH-1]) ? -opdata1 : opdata1;
    w_abs2 = (signed_div && opdata2[DATA_WIDTH-1]) ? -opdata2 : opdata2;
  end

  // Result of the last iteration with sign correction or divide-by-zero value
  always_comb begin
    w_quot_raw = {r_dq[DATA_WIDTH-2:0], w_q_bit};
    if (r_divisor == c_zero) begin
      w_final = {r_op1_raw, c_all_ones};
    end else begin
      w_final[DATA_WIDTH-1:0]            = (r_signed && r_sign_q) ? -w_quot_raw : w_quot_raw;
      w_final[2*DATA_WIDTH-1:DATA_WIDTH] = (r_signed && r_sign_r) ? -w_rem_next : w_rem_next;
    end
  end

  // Sequencer: capture, iterate, hold result until EX drops start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= 6'd0;
      r_rem     <= c_zero;
      r_dq      <= c_zero;
      r_divisor <= c_zero;
      r_op1_raw <= c_zero;
      r_signed  <= 1'b0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else if (annul) begin
      // Flush wins over everything; the last result stays visible
      r_state <= DIV_IDLE;
      r_cnt   <= 6'd0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_cnt     <= 6'd0;
            r_rem     <= c_zero;
            r_dq      <= w_abs1;
            r_divisor <= w_abs2;
            r_op1_raw <= opdata1;
            r_signed  <= signed_div;
            r_sign_q  <= signed_div & (opdata1[DATA_WIDTH-1] ^ opdata2[DATA_WIDTH-1]);
            r_sign_r  <= signed_div & opdata1[DATA_WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
            r_state   <= (opdata2 == c_zero) ? DIV_ZERO : DIV_RUN;
`else
            r_state   <= DIV_RUN;
`endif
          end
        end
        DIV_RUN: begin
          r_rem <= w_rem_next;
          r_dq  <= w_quot_raw;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_last_cnt) begin
            r_state  <= DIV_DONE;
            r_result <= w_final;
            r_ready  <= 1'b1;
          end
        end
`ifdef DIV_ZERO_FAST_EN
        DIV_ZERO: begin
          r_state  <= DIV_DONE;
          r_result <= {r_op1_raw, c_all_ones};
          r_ready  <= 1'b1;
        end
`endif
        DIV_DONE: begin
          if (!start) begin
            r_state <= DIV_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= DIV_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign result    = r_result;
  assign ready     = r_ready;
  assign busy      = (r_state != DIV_IDLE);
  assign stall_req = start & ~r_ready & ~annul;

endmodule
`default_nettype wire
